axi4_lite_read_arbiter: RTL

Two-port round-robin arbiter and sequencer that shares a single AXI4-Lite read master port between two requesters: port 0 (instruction fetch) and port 1 (data load). It accepts a simple valid/done request per port, runs one complete AR/R transaction at a time on the shared bus, and returns the read data and response to the winning requester. It sits between the core's memory interfaces and the AXI4-Lite read slave.

---
 rtl/axi4_lite_read_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/axi4_lite_read_arbiter.sv
// axi4_lite_read_arbiter
// Shares one AXI4-Lite read master port between two requesters. Port 0 is
// instruction fetch and port 1 is data load. One complete AR/R transaction
// runs at a time. Round-robin arbitration is used when both ports request.
//
// Ports:
//   axi_clk, reset           clock and synchronous active-high reset
//   reqN_valid / reqN_addr   request from port N. The requester holds these
//                            until reqN_done.
//   reqN_done                one-cycle pulse. reqN_data and reqN_resp are
//                            valid in that cycle.
//   reqN_data / reqN_resp    read result. Holds until that port's next done.
//   m_ar* / m_r*             AXI4-Lite read address and read data channels
//   busy                     high whenever the FSM is not in IDLE
//   grant                    index of the current or most recent winner
//
// Handshake semantics:
//   An AXI beat transfers on a rising edge where both valid and ready are
//   high. m_arvalid and m_araddr stay stable until m_arready is seen.
//   m_rready is raised only after the AR beat has transferred, so m_arvalid
//   and m_rready are never high together. A requester asserts reqN_valid and
//   waits for reqN_done. Requests are sampled only in IDLE. Once a request
//   is accepted, the AXI transaction always completes, even if the requester
//   drops its valid.
module axi4_lite_read_arbiter #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     axi_clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  output logic                     req0_done,
  output logic [31:0]              req0_data,
  output logic [1:0]               req0_resp,
  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  output logic                     req1_done,
  output logic [31:0]              req1_data,
  output logic [1:0]               req1_resp,
  output logic [ADDRESS_WIDTH-1:0] m_araddr,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [31:0]              m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  output logic                     busy,
  output logic                     grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   start;      // a request is accepted this cycle
  logic   win;        // winning port for the request being accepted
  logic   capture;    // the R beat transfers this cycle

  // Next-state logic and arbitration
  always_comb begin
    state_next = state;
    start      = 1'b0;
    win        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          start      = 1'b1;
          state_next = ADDR;
          // When both ports request, the port that did not win last time
          // is served.
          if (req0_valid && req1_valid) win = ~last_grant;
          else                          win = req1_valid;
        end
      end
      ADDR: if (m_arready) state_next = DATA;
      DATA: begin
        if (m_rvalid) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and registered outputs. All outputs are derived from
  // state_next so that each output is valid in the same cycle as its state.
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      state      <= IDLE;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      m_araddr   <= '0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_data  <= '0;
      req1_data  <= '0;
      req0_resp  <= '0;
      req1_resp  <= '0;
      busy       <= 1'b0;
      grant      <= 1'b0;
      // Resetting last_grant to 1 makes port 0 win the first contention.
      last_grant <= 1'b1;
    end else begin
      state     <= state_next;
      m_arvalid <= (state_next == ADDR);
      m_rready  <= (state_next == DATA);
      busy      <= (state_next != IDLE);
      req0_done <= capture && !grant;
      req1_done <= capture &&  grant;
      if (start) begin
        grant    <= win;
        m_araddr <= win ? req1_addr : req0_addr;
      end
      if (capture) begin
        last_grant <= grant;
        if (grant) begin
          req1_data <= m_rdata;
          req1_resp <= m_rresp;
        end else begin
          req0_data <= m_rdata;
          req0_resp <= m_rresp;
        end
      end
    end
  end

endmodule
